// File: rtl/adder_result_accum.sv
// Accumulates BURST_LEN adder sums into one ACC_W-bit result; optional saturation via ADDER_RESULT_ACCUM_SAT_EN.
// Latency: result valid the cycle after the final accepted sample. Backpressure: in_ready low while a result waits on out_ready.
module adder_result_accum #(
    parameter int BURST_LEN = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_trk_q, ovf_trk_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W:0]   add_full;
    logic             add_ovf;
    logic [ACC_W-1:0] add_res;

    // clear is allowed to gate in_ready combinationally; in_valid/out_ready never reach it
    assign in_ready  = (state_q != HOLD) && !clear;
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;
    assign accept    = in_valid && in_ready;

    assign sum_ext  = {{(ACC_W-2){1'b0}}, sum_in};
    assign add_full = {1'b0, acc_q} + sum_ext;
    assign add_ovf  = add_full[ACC_W];

`ifdef ADDER_RESULT_ACCUM_SAT_EN
    assign add_res = add_ovf ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    assign add_res = add_full[ACC_W-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_trk_d  = ovf_trk_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    acc_d     = sum_ext[ACC_W-1:0];
                    cnt_d     = 8'd1;
                    ovf_trk_d = 1'b0;
                    if (BURST_LEN_C == 8'd1) begin
                        state_d    = HOLD;
                        out_data_d = sum_ext[ACC_W-1:0];
                        ovf_d      = 1'b0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (clear) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    acc_d     = add_res;
                    cnt_d     = cnt_q + 8'd1;
                    ovf_trk_d = ovf_trk_q | add_ovf;
                    if (cnt_d == BURST_LEN_C) begin
                        state_d    = HOLD;
                        out_data_d = add_res;
                        ovf_d      = ovf_trk_q | add_ovf;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_trk_q  <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_trk_q  <= ovf_trk_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_adder_result_accum.sv
// Bench for adder_result_accum: directed scenarios plus a randomized run against a burst-sum model.
module tb_adder_result_accum;

    localparam int BL = 4;

    logic       clk, rst_n, in_valid, clear, out_ready;
    logic [2:0] sum_in;

    logic       rdy_a, vld_a, ovf_a;
    logic [7:0] dat_a;
    logic       rdy_w, vld_w, ovf_w;
    logic [3:0] dat_w;
    logic       rdy_b, vld_b, ovf_b;
    logic [7:0] dat_b;

    int total = 0;
    int bad   = 0;

    adder_result_accum #(.BURST_LEN(4), .ACC_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(rdy_a),
        .clear(clear), .out_data(dat_a), .out_valid(vld_a), .out_ready(out_ready), .ovf(ovf_a));

    adder_result_accum #(.BURST_LEN(4), .ACC_W(4)) u_dut_w4 (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(rdy_w),
        .clear(clear), .out_data(dat_w), .out_valid(vld_w), .out_ready(out_ready), .ovf(ovf_w));

    adder_result_accum #(.BURST_LEN(1), .ACC_W(8)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(rdy_b),
        .clear(clear), .out_data(dat_b), .out_valid(vld_b), .out_ready(out_ready), .ovf(ovf_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Result of a complete burst from its plain arithmetic total
    function automatic int exp_res(input int tot, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef ADDER_RESULT_ACCUM_SAT_EN
        return (tot > mx) ? mx : tot;
`else
        return tot % (1 << w);
`endif
    endfunction

    task automatic drive(input logic v, input int s, input logic c, input logic r);
        @(negedge clk);
        in_valid  = v;
        sum_in    = 3'(s);
        clear     = c;
        out_ready = r;
        #1;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; sum_in = 3'd0; clear = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        apply_reset();
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_rdy_a got=%b exp=1", rdy_a); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_vld_a got=%b exp=0", vld_a); end
        total++; if (dat_a !== 8'd0) begin bad++; $display("FAIL reset_dat_a got=%0d exp=0", dat_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf_a got=%b exp=0", ovf_a); end
        total++; if (rdy_w !== 1'b1 || vld_w !== 1'b0) begin bad++; $display("FAIL reset_hs_w got=%b%b exp=10", rdy_w, vld_w); end
        total++; if (dat_w !== 4'd0 || ovf_w !== 1'b0) begin bad++; $display("FAIL reset_out_w got=%0d/%b exp=0/0", dat_w, ovf_w); end
        total++; if (rdy_b !== 1'b1 || vld_b !== 1'b0) begin bad++; $display("FAIL reset_hs_b got=%b%b exp=10", rdy_b, vld_b); end
        total++; if (dat_b !== 8'd0 || ovf_b !== 1'b0) begin bad++; $display("FAIL reset_out_b got=%0d/%b exp=0/0", dat_b, ovf_b); end
    endtask

    task automatic test_basic;
        int s[4] = '{2, 4, 4, 5};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b1);
            total++; if (rdy_a !== 1'b1 || vld_a !== 1'b0) begin bad++; $display("FAIL basic_accept%0d rdy/vld=%b%b exp=10", i, rdy_a, vld_a); end
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL basic_vld got=%b exp=1", vld_a); end
        total++; if (dat_a !== 8'd15) begin bad++; $display("FAIL basic_dat got=%0d exp=15", dat_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", ovf_a); end
        drive(1'b0, 0, 1'b0, 1'b1);
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL basic_vld_drop got=%b exp=0", vld_a); end
        total++; if (dat_a !== 8'd15) begin bad++; $display("FAIL basic_dat_held got=%0d exp=15", dat_a); end
    endtask

    task automatic test_overflow;
        logic [3:0] e4;
        apply_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 6, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        e4 = 4'(exp_res(24, 4));
        total++; if (vld_w !== 1'b1) begin bad++; $display("FAIL ovf_vld_w got=%b exp=1", vld_w); end
        total++; if (dat_w !== e4) begin bad++; $display("FAIL ovf_dat_w got=%0d exp=%0d", dat_w, e4); end
        total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL ovf_flag_w got=%b exp=1", ovf_w); end
        total++; if (dat_a !== 8'd24 || ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_wide got=%0d/%b exp=24/0", dat_a, ovf_a); end
    endtask

    task automatic test_hold;
        apply_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(k == 2, 6, k == 2, 1'b0);
            total++; if (vld_a !== 1'b1 || dat_a !== 8'd4 || rdy_a !== 1'b0)
                begin bad++; $display("FAIL hold_stable%0d vld/dat/rdy=%b/%0d/%b exp=1/4/0", k, vld_a, dat_a, rdy_a); end
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        total++; if (vld_a !== 1'b1 || dat_a !== 8'd4) begin bad++; $display("FAIL hold_handshake vld/dat=%b/%0d exp=1/4", vld_a, dat_a); end
        drive(1'b0, 0, 1'b0, 1'b0);
        total++; if (vld_a !== 1'b0 || rdy_a !== 1'b1) begin bad++; $display("FAIL hold_release vld/rdy=%b/%b exp=0/1", vld_a, rdy_a); end
    endtask

    task automatic test_clear;
        apply_reset();
        drive(1'b1, 3, 1'b0, 1'b1);
        drive(1'b1, 3, 1'b0, 1'b1);
        drive(1'b1, 6, 1'b1, 1'b1);
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL clear_rdy got=%b exp=0", rdy_a); end
        for (int i = 0; i < 4; i++) drive(1'b1, 1, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        total++; if (vld_a !== 1'b1 || dat_a !== 8'd4 || ovf_a !== 1'b0)
            begin bad++; $display("FAIL clear_result vld/dat/ovf=%b/%0d/%b exp=1/4/0", vld_a, dat_a, ovf_a); end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 2, 1'b0, 1'b1);
        drive(1'b1, 2, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; sum_in = 3'd6; clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; clear = 1'b0;
        #1;
        total++; if (rdy_a !== 1'b1 || vld_a !== 1'b0 || dat_a !== 8'd0 || ovf_a !== 1'b0)
            begin bad++; $display("FAIL rstmid_outputs rdy/vld/dat/ovf=%b/%b/%0d/%b exp=1/0/0/0", rdy_a, vld_a, dat_a, ovf_a); end
        for (int i = 0; i < 4; i++) drive(1'b1, 5, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        total++; if (vld_a !== 1'b1 || dat_a !== 8'd20 || ovf_a !== 1'b0)
            begin bad++; $display("FAIL rstmid_result vld/dat/ovf=%b/%0d/%b exp=1/20/0", vld_a, dat_a, ovf_a); end
    endtask

    task automatic test_burst1;
        int s[3] = '{6, 0, 3};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b1);
            total++; if (rdy_b !== 1'b1 || vld_b !== 1'b0) begin bad++; $display("FAIL b1_accept%0d rdy/vld=%b%b exp=10", i, rdy_b, vld_b); end
            drive(1'b1, s[i], 1'b0, 1'b1);
            total++; if (rdy_b !== 1'b0 || vld_b !== 1'b1 || dat_b !== 8'(s[i]))
                begin bad++; $display("FAIL b1_result%0d rdy/vld/dat=%b/%b/%0d exp=0/1/%0d", i, rdy_b, vld_b, dat_b, s[i]); end
        end
    endtask

    task automatic test_random;
        bit hold = 0;
        int q[$];
        int e8 = 0, e4 = 0, tot;
        bit o8 = 0, o4 = 0;
        bit v, c, r;
        int s;
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            v = ($urandom % 10) < 7;
            s = $urandom % 7;
            c = ($urandom % 20) == 0;
            r = $urandom % 2;
            drive(v, s, c, r);
            total++;
            if (rdy_a !== (!hold && !c) || vld_a !== hold || dat_a !== 8'(e8) || ovf_a !== o8) begin
                bad++;
                if (bad < 20) $display("FAIL rand_w8 cyc=%0d rdy/vld/dat/ovf=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                                       n, rdy_a, vld_a, dat_a, ovf_a, !hold && !c, hold, e8, o8);
            end
            total++;
            if (rdy_w !== (!hold && !c) || vld_w !== hold || dat_w !== 4'(e4) || ovf_w !== o4) begin
                bad++;
                if (bad < 20) $display("FAIL rand_w4 cyc=%0d rdy/vld/dat/ovf=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                                       n, rdy_w, vld_w, dat_w, ovf_w, !hold && !c, hold, e4, o4);
            end
            if (hold) begin
                if (r) hold = 0;
            end else if (c) begin
                q.delete();
            end else if (v) begin
                q.push_back(s);
                if (q.size() == BL) begin
                    tot = 0;
                    foreach (q[k]) tot += q[k];
                    e8 = exp_res(tot, 8);
                    e4 = exp_res(tot, 4);
                    o8 = tot > 255;
                    o4 = tot > 15;
                    hold = 1;
                    q.delete();
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; sum_in = 3'd0; clear = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_hold();
        test_clear();
        test_reset_mid();
        test_burst1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_result_accum.md
ADDER_RESULT_ACCUM -- requirements
Module: adder_result_accum

Interface
REQ-001 Parameter BURST_LEN, default 4, sums per accumulated result, legal range 1..255.
REQ-002 Parameter ACC_W, default 8, accumulator and result width, legal range 4..16.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port sum_in  input  3  unsigned sum consumed from the upstream 2-bit adder output, range 0..6.
REQ-006 Port in_valid  input  1  sum_in valid this cycle.
REQ-007 Port in_ready  output  1  block accepts sum_in this cycle.
REQ-008 Port clear  input  1  synchronous abort of the current burst.
REQ-009 Port out_data  output  ACC_W  accumulated burst result.
REQ-010 Port out_valid  output  1  out_data valid.
REQ-011 Port out_ready  input  1  downstream accepts out_data.
REQ-012 Port ovf  output  1  overflow occurred in the presented burst.

Function
REQ-013 The block SHALL accept a sample only when in_valid and in_ready are both 1 on a rising edge.
REQ-014 The block SHALL implement the states IDLE, ACCUM and HOLD.
REQ-015 IDLE: in_ready=1; an accepted sample SHALL load acc=sum_in, cnt=1, clear the ovf tracker, then go to HOLD if BURST_LEN==1, else to ACCUM.
REQ-016 ACCUM: in_ready=1; an accepted sample SHALL set acc=acc+sum_in and cnt=cnt+1; on the accept making cnt==BURST_LEN the block SHALL go to HOLD.
REQ-017 ACCUM with in_valid=0 SHALL hold acc, cnt and state; gaps of any length are legal.
REQ-018 HOLD: in_ready=0, out_valid=1, out_data=acc, ovf=tracker; all three SHALL stay stable until out_valid&out_ready, then go to IDLE.
REQ-019 Latency: out_valid SHALL assert on the first rising edge after the final sample is accepted; a new burst sample SHALL be accepted no earlier than the cycle after the handshake.
REQ-020 Outside HOLD, out_valid=0, and out_data and ovf SHALL hold their last values.
REQ-021 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-022 Arithmetic SHALL be unsigned; sum_in is zero-extended to ACC_W+1 bits before addition.
REQ-023 An addition whose true result exceeds 2^ACC_W-1 SHALL set the ovf tracker, which stays set until the next burst start.
REQ-024 clear=1 in IDLE or ACCUM SHALL force in_ready=0 that cycle, discard acc and cnt, and enter IDLE; a simultaneous in_valid sample is dropped.
REQ-025 clear=1 in HOLD SHALL be ignored; the pending result is never discarded.
REQ-026 cnt SHALL be 8 bits wide and SHALL never exceed BURST_LEN.

Reset
REQ-027 rst_n=0 on a rising edge SHALL force state IDLE, acc=0, cnt=0, out_data=0, ovf=0, out_valid=0 and in_ready=1 on the following cycle.
REQ-028 Reset SHALL take priority over clear and all handshakes, including mid-burst and in HOLD; the pending result is lost.

Configuration
REQ-029 Macro ADDER_RESULT_ACCUM_SAT_EN defined: on overflow acc SHALL saturate at 2^ACC_W-1 and remain there for the rest of the burst.
REQ-030 Macro ADDER_RESULT_ACCUM_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W.
REQ-031 ovf behaviour SHALL be identical with and without the macro.

Verification
REQ-032 BURST_LEN=4, ACC_W=8, samples 2,4,4,5 back-to-back, out_ready=1 -> out_valid for exactly 1 cycle, one cycle after the 4th accept, out_data=15, ovf=0.
REQ-033 ACC_W=4, BURST_LEN=4, samples 6,6,6,6 -> macro undefined: out_data=8, ovf=1; macro defined: out_data=15, ovf=1.
REQ-034 BURST_LEN=4, burst 1,1,1,1 with out_ready=0 for 5 cycles -> out_valid=1, out_data=4 stable, in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-035 BURST_LEN=4, samples 3,3 then clear together with in_valid and sum_in=6, then samples 1,1,1,1 -> out_data=4, not 10 or 16.
REQ-036 BURST_LEN=4, rst_n=0 for 1 cycle after 2 samples, then samples 5,5,5,5 -> outputs at reset values the cycle after reset, then out_data=20, ovf=0.
REQ-037 BURST_LEN=1, samples 6,0,3 with out_ready=1 and in_valid held high -> three results 6,0,3, in_ready toggling 1,0.
